alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor of the single-cycle ALU: WIDTH-bit operands, 4-bit opcode, valid/ready handshake on input and output.
- Adds a running accumulator, status flags (zero, signed overflow, illegal-op) and full back-pressure support.
- Sits between a stimulus/issue source and a result consumer; replaces the fixed-width ALU in the class-based environment.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4)
- SHW, $clog2(WIDTH), shift-amount bits taken from B (derived, not overridden)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Sel  input  4  opcode
- in_valid  input  1  A/B/Sel valid
- in_ready  output  1  block accepts operands this cycle
- Y  output  WIDTH  result
- C  output  1  carry / borrow / shifted-out bit
- Z  output  1  Y == 0
- V  output  1  signed overflow (ADD/SUB/ACC only)
- err  output  1  illegal opcode
- out_valid  output  1  Y/C/Z/V/err valid
- out_ready  input  1  consumer takes result this cycle

Behaviour:
- One clock (clk); reset rst is asynchronous, active-low. While rst=0: s1_valid=0, s2_valid=0, accumulator=0, multiplier counter=0, Y=0, C=0, Z=0, V=0, err=0, out_valid=0. Reset mid-operation discards all in-flight ops.
- Two stages. S1 captures A/B/Sel on in_valid&&in_ready. S2 computes and registers result/flags.
- Handshake: s2_adv = !s2_valid || out_ready; s1_adv = s1_valid && s2_adv && !mul_busy; in_ready = !s1_valid || s1_adv. Transfer on valid&&ready only; outputs stable while out_valid&&!out_ready.
- Latency: accept at edge N -> out_valid at edge N+2 (non-MUL, no stall). Throughput 1 op/cycle with out_ready=1.
- Opcodes:
  - 0 ADD: Y=A+B, C=carry-out, V=signed overflow
  - 1 SUB: Y=A-B, C=1 when A<B unsigned, V=signed overflow
  - 2 AND, 3 OR, 4 XOR, 5 NOT (~A)
  - 6 SHL: Y=A<<B[SHW-1:0], C=last bit shifted out (0 if shift 0)
  - 7 SHR: logical right shift, same C rule
  - 8 CMP: Y={0..,A<B unsigned}
  - 9 PASS: Y=A
  - 10 ACC: acc<=acc+A, Y=new acc, C=carry, V=signed overflow
  - 11 CLR: acc<=0, Y=0
  - 12 MUL: only with optional feature
  - 13-15: illegal
- C/V=0 for opcodes not listed as driving them. Z=(Y==0) for every op, including illegal ones.
- Illegal op: Y=0, err=1, accumulator unchanged. err=0 otherwise.
- Accumulator updates only when an ACC/CLR op loads S2, never on stall.
- Back-to-back ACC ops see each other's results, with no hazard.
- Arithmetic wraps modulo 2^WIDTH.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: opcode 12 MUL is legal.
  - Y = low WIDTH bits of A*B unsigned; C=1 if the high half is nonzero.
  - Iterative shift-add: MUL in S1 sets mul_busy for exactly WIDTH cycles before S1 may advance; in_ready=0 meanwhile.
  - Latency WIDTH+2 cycles.
  - Reset clears the counter.
- Undefined: opcode 12 is illegal (Y=0, err=1, latency 2); no multiplier logic.

Test Plan:
- Reset mid-stream: issue ADD, assert rst=0 one cycle later -> out_valid=0, all outputs 0, acc=0; first op after release gives a correct result.
- WIDTH=8 ADD A=8'hFF B=8'h01 -> Y=8'h00, C=1, Z=1, V=0; ADD 8'h7F+8'h01 -> Y=8'h80, V=1, C=0; SUB 8'h03-8'h05 -> Y=8'hFE, C=1.
- Back-pressure: stream 4 PASS ops (A=1,2,3,4) with out_ready held 0 for 5 cycles -> in_ready drops after 2 accepts; outputs 1,2,3,4 in order with none lost or duplicated; Y held stable during stall.
- Accumulator: CLR, ACC A=10, ACC A=20, ACC A=250 back-to-back -> Y=0,10,30,24 (C=1 on the last).
- SHL A=8'h81 B=1 -> Y=8'h02, C=1; opcode 14 -> Y=0, err=1, Z=1.
- ALU_MUL_EN defined: MUL 8'h10*8'h11 -> Y=8'h10, C=1, out_valid 10 cycles after accept, in_ready low 8 cycles. Undefined: same stimulus -> err=1.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both
// sides, a running accumulator and zero / signed-overflow / illegal-op flags.
// Optional feature: define ALU_MUL_EN to make opcode 12 an iterative
// shift-add multiply; without it opcode 12 is treated as illegal.
module alu_pipe #(
   parameter int WIDTH = 8,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       Sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Y,
   output logic             C,
   output logic             Z,
   output logic             V,
   output logic             err,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_CMP  = 4'd8;
   localparam logic [3:0] OP_PASS = 4'd9;
   localparam logic [3:0] OP_ACC  = 4'd10;
   localparam logic [3:0] OP_CLR  = 4'd11;

   // Stage 1 holds the captured operands, stage 2 the registered result.
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
   logic [3:0]       sel1_q, sel1_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             c_q, c_d, z_q, z_d, v_q, v_d, err_q, err_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             s1_adv, s2_adv, mul_busy;
   logic [WIDTH-1:0] res_y;
   logic             res_c, res_v, res_err;
   logic [WIDTH:0]   add_w, sub_w, acc_w, shl_w, shr_w;

`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'd12;
   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]      mul_cnt_q, mul_cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [2*WIDTH-1:0] mul_term;

   // A MUL sitting in stage 1 holds the pipe until all WIDTH partial products are summed.
   always_comb begin
      mul_busy = s1_valid_q && (sel1_q == OP_MUL) && (mul_cnt_q != CW'(WIDTH));
      mul_term = b1_q[mul_cnt_q[SHW-1:0]] ? ({{WIDTH{1'b0}}, a1_q} << mul_cnt_q) : '0;
      mul_cnt_d = mul_cnt_q;
      prod_d = prod_q;
      if (s1_adv) begin
         mul_cnt_d = '0;
      end else if (mul_busy) begin
         mul_cnt_d = mul_cnt_q + 1'b1;
         prod_d = ((mul_cnt_q == '0) ? '0 : prod_q) + mul_term;
      end
   end

   // Multiplier iteration state; a reset abandons any product in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_cnt_q <= '0;
         prod_q <= '0;
      end else begin
         mul_cnt_q <= mul_cnt_d;
         prod_q <= prod_d;
      end
   end
`else
   assign mul_busy = 1'b0;
`endif

   // Handshake: stage 2 drains when the consumer takes it, stage 1 moves when stage 2 has room.
   always_comb begin
      s2_adv = !s2_valid_q || out_ready;
      s1_adv = s1_valid_q && s2_adv && !mul_busy;
      in_ready = !s1_valid_q || s1_adv;
   end

   // Stage 2 datapath: compute result and flags from the stage-1 operands.
   always_comb begin
      add_w = {1'b0, a1_q} + {1'b0, b1_q};
      sub_w = {1'b0, a1_q} - {1'b0, b1_q};
      acc_w = {1'b0, acc_q} + {1'b0, a1_q};
      shl_w = {1'b0, a1_q} << b1_q[SHW-1:0];
      shr_w = {a1_q, 1'b0} >> b1_q[SHW-1:0];
      res_y = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      res_err = 1'b0;
      acc_d = acc_q;
      case (sel1_q)
         OP_ADD: begin
            res_y = add_w[WIDTH-1:0];
            res_c = add_w[WIDTH];
            res_v = (a1_q[WIDTH-1] == b1_q[WIDTH-1]) && (add_w[WIDTH-1] != a1_q[WIDTH-1]);
         end
         OP_SUB: begin
            res_y = sub_w[WIDTH-1:0];
            res_c = sub_w[WIDTH];
            res_v = (a1_q[WIDTH-1] != b1_q[WIDTH-1]) && (sub_w[WIDTH-1] != a1_q[WIDTH-1]);
         end
         OP_AND:  res_y = a1_q & b1_q;
         OP_OR:   res_y = a1_q | b1_q;
         OP_XOR:  res_y = a1_q ^ b1_q;
         OP_NOT:  res_y = ~a1_q;
         OP_SHL: begin
            res_y = shl_w[WIDTH-1:0];
            res_c = shl_w[WIDTH];
         end
         OP_SHR: begin
            res_y = shr_w[WIDTH:1];
            res_c = shr_w[0];
         end
         OP_CMP:  res_y = {{(WIDTH-1){1'b0}}, (a1_q < b1_q)};
         OP_PASS: res_y = a1_q;
         OP_ACC: begin
            res_y = acc_w[WIDTH-1:0];
            res_c = acc_w[WIDTH];
            res_v = (acc_q[WIDTH-1] == a1_q[WIDTH-1]) && (acc_w[WIDTH-1] != acc_q[WIDTH-1]);
            if (s1_adv) acc_d = acc_w[WIDTH-1:0];
         end
         OP_CLR: begin
            res_y = '0;
            if (s1_adv) acc_d = '0;
         end
`ifdef ALU_MUL_EN
         OP_MUL: begin
            res_y = prod_q[WIDTH-1:0];
            res_c = |prod_q[2*WIDTH-1:WIDTH];
         end
`endif
         default: res_err = 1'b1;
      endcase
   end

   // Next-state for both stages; results are held while the consumer stalls.
   always_comb begin
      s1_valid_d = s1_valid_q;
      a1_d = a1_q;
      b1_d = b1_q;
      sel1_d = sel1_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            a1_d = A;
            b1_d = B;
            sel1_d = Sel;
         end
      end
      s2_valid_d = s2_valid_q;
      y_d = y_q;
      c_d = c_q;
      z_d = z_q;
      v_d = v_q;
      err_d = err_q;
      if (s1_adv) begin
         s2_valid_d = 1'b1;
         y_d = res_y;
         c_d = res_c;
         z_d = (res_y == '0);
         v_d = res_v;
         err_d = res_err;
      end else if (s2_adv) begin
         s2_valid_d = 1'b0;
      end
   end

   // Pipeline and accumulator registers; reset drops every in-flight op.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         a1_q <= '0;
         b1_q <= '0;
         sel1_q <= '0;
         s2_valid_q <= 1'b0;
         y_q <= '0;
         c_q <= 1'b0;
         z_q <= 1'b0;
         v_q <= 1'b0;
         err_q <= 1'b0;
         acc_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         a1_q <= a1_d;
         b1_q <= b1_d;
         sel1_q <= sel1_d;
         s2_valid_q <= s2_valid_d;
         y_q <= y_d;
         c_q <= c_d;
         z_q <= z_d;
         v_q <= v_d;
         err_q <= err_d;
         acc_q <= acc_d;
      end
   end

   assign Y = y_q;
   assign C = c_q;
   assign Z = z_q;
   assign V = v_q;
   assign err = err_q;
   assign out_valid = s2_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe at WIDTH=8. Expected results are
// queued as operands are issued and checked as the DUT hands results out.
// Define ALU_MUL_EN for both bench and RTL to exercise the multiplier.
module tb_alu_pipe;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] A = '0, B = '0;
   logic [3:0] Sel = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] Y;
   logic       C, Z, V, err, out_valid;
   logic       out_ready = 1'b1;

   typedef struct packed {
      logic [7:0] y;
      logic       c;
      logic       v;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   assertions = 0;
   int   failures = 0;

   alu_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .Sel(Sel),
      .in_valid(in_valid), .in_ready(in_ready),
      .Y(Y), .C(C), .Z(Z), .V(V), .err(err),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Hard stop so a wedged pipeline can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Monitor: pop and compare on every handshake, and check outputs hold during a stall.
   initial begin
      logic       prev_stall;
      logic [7:0] held_y;
      logic       held_c, held_z, held_v, held_e;
      exp_t       e;
      prev_stall = 1'b0;
      held_y = '0;
      {held_c, held_z, held_v, held_e} = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && out_valid) begin
               assertions++;
               if ({Y, C, Z, V, err} !== {held_y, held_c, held_z, held_v, held_e}) begin
                  failures++;
                  $display("[TB] FAIL stall_hold: got Y=%h CZVE=%b%b%b%b, held Y=%h CZVE=%b%b%b%b",
                           Y, C, Z, V, err, held_y, held_c, held_z, held_v, held_e);
               end
            end
            prev_stall = out_valid && !out_ready;
            {held_y, held_c, held_z, held_v, held_e} = {Y, C, Z, V, err};
            if (out_valid && out_ready) begin
               assertions++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("[TB] FAIL unexpected_output: got Y=%h with empty scoreboard", Y);
               end else begin
                  e = sb.pop_front();
                  if (Y !== e.y || C !== e.c || V !== e.v || err !== e.err || Z !== (e.y == 8'h00)) begin
                     failures++;
                     $display("[TB] FAIL result: got Y=%h C=%b Z=%b V=%b err=%b, expected Y=%h C=%b Z=%b V=%b err=%b",
                              Y, C, Z, V, err, e.y, e.c, (e.y == 8'h00), e.v, e.err);
                  end
               end
            end
         end
      end
   end

   // Present one operation and wait (bounded) for it to be accepted.
   task automatic applyOp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                          input logic [7:0] ey, input logic ec, input logic ev, input logic ee);
      int waited;
      exp_t e;
      e.y = ey; e.c = ec; e.v = ev; e.err = ee;
      sb.push_back(e);
      A = a; B = b; Sel = sel; in_valid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         assertions++;
         failures++;
         $display("[TB] FAIL accept_timeout: in_ready=%b, required 1 within 100 cycles", in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Wait (bounded) until every queued result has come out.
   task automatic drain();
      int waited = 0;
      while (sb.size() != 0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      assertions++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain: %0d results outstanding, required 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Reset values, then reset in the middle of an op and recover cleanly.
   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      assertions++;
      if ({out_valid, Y, C, Z, V, err, in_ready} !== {1'b0, 8'h00, 4'b0000, 1'b1}) begin
         failures++;
         $display("[TB] FAIL reset_state: got ov=%b Y=%h CZVE=%b%b%b%b ir=%b, required ov=0 Y=00 CZVE=0000 ir=1",
                  out_valid, Y, C, Z, V, err, in_ready);
      end
      rst = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      A = 8'h11; B = 8'h22; Sel = 4'd0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      assertions++;
      if ({out_valid, Y, C, Z, V, err} !== {1'b0, 8'h00, 4'b0000}) begin
         failures++;
         $display("[TB] FAIL reset_midstream: got ov=%b Y=%h CZVE=%b%b%b%b, required all 0",
                  out_valid, Y, C, Z, V, err);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      out_ready = 1'b1;
      sb.delete();
      applyOp(8'h05, 8'h00, 4'd10, 8'h05, 1'b0, 1'b0, 1'b0);
      applyOp(8'h12, 8'h34, 4'd0, 8'h46, 1'b0, 1'b0, 1'b0);
      drain();
   endtask

   // Add/subtract carry, borrow and overflow corner cases.
   task automatic test_arith();
      applyOp(8'hFF, 8'h01, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
      applyOp(8'h7F, 8'h01, 4'd0, 8'h80, 1'b0, 1'b1, 1'b0);
      applyOp(8'h03, 8'h05, 4'd1, 8'hFE, 1'b1, 1'b0, 1'b0);
      applyOp(8'h80, 8'h01, 4'd1, 8'h7F, 1'b0, 1'b1, 1'b0);
      drain();
   endtask

   // Bitwise, compare and pass ops on random operands against a small reference.
   task automatic test_logic();
      logic [7:0] a, b, ey;
      logic [3:0] op;
      for (int i = 0; i < 12; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         op = 4'(2 + (i % 6));
         if (op == 4'd6) op = 4'd8;
         if (op == 4'd7) op = 4'd9;
         case (op)
            4'd2: ey = a & b;
            4'd3: ey = a | b;
            4'd4: ey = a ^ b;
            4'd5: ey = ~a;
            4'd8: ey = (a < b) ? 8'd1 : 8'd0;
            default: ey = a;
         endcase
         applyOp(a, b, op, ey, 1'b0, 1'b0, 1'b0);
      end
      drain();
   endtask

   // Four PASS ops while the consumer stalls for five cycles.
   task automatic test_backpressure();
      #0 out_ready = 1'b0;
      fork
         begin
            for (int i = 1; i <= 4; i++) applyOp(8'(i), 8'h00, 4'd9, 8'(i), 1'b0, 1'b0, 1'b0);
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            assertions++;
            if (in_ready !== 1'b0) begin
               failures++;
               $display("[TB] FAIL bp_in_ready: got %b, required 0 with both stages full", in_ready);
            end
            out_ready = 1'b1;
         end
      join
      drain();
   endtask

   // Accumulator chain with wrap-around on the last add.
   task automatic test_acc();
      applyOp(8'h00, 8'h00, 4'd11, 8'd0, 1'b0, 1'b0, 1'b0);
      applyOp(8'd10, 8'h00, 4'd10, 8'd10, 1'b0, 1'b0, 1'b0);
      applyOp(8'd20, 8'h00, 4'd10, 8'd30, 1'b0, 1'b0, 1'b0);
      applyOp(8'd250, 8'h00, 4'd10, 8'd24, 1'b1, 1'b0, 1'b0);
      drain();
   endtask

   // Shifts with and without shifted-out bits, then illegal opcodes.
   task automatic test_shift_illegal();
      applyOp(8'h81, 8'h01, 4'd6, 8'h02, 1'b1, 1'b0, 1'b0);
      applyOp(8'h81, 8'h01, 4'd7, 8'h40, 1'b1, 1'b0, 1'b0);
      applyOp(8'h81, 8'h00, 4'd6, 8'h81, 1'b0, 1'b0, 1'b0);
      applyOp(8'h0F, 8'h04, 4'd7, 8'h00, 1'b1, 1'b0, 1'b0);
      applyOp(8'h12, 8'h34, 4'd14, 8'h00, 1'b0, 1'b0, 1'b1);
      applyOp(8'hFF, 8'hFF, 4'd13, 8'h00, 1'b0, 1'b0, 1'b1);
      applyOp(8'd7, 8'h00, 4'd10, 8'd31, 1'b0, 1'b0, 1'b0);
      drain();
   endtask

   // Opcode 12: multiply when enabled, illegal otherwise; check latency and stall length.
   task automatic test_mul();
      int cycles = 0;
      int low = 0;
`ifdef ALU_MUL_EN
      applyOp(8'h10, 8'h11, 4'd12, 8'h10, 1'b1, 1'b0, 1'b0);
`else
      applyOp(8'h10, 8'h11, 4'd12, 8'h00, 1'b0, 1'b0, 1'b1);
`endif
      do begin
         @(negedge clk);
         cycles++;
         if (!in_ready) low++;
      end while (!out_valid && cycles < 50);
      assertions++;
`ifdef ALU_MUL_EN
      if (cycles != 10 || low != 8) begin
         failures++;
         $display("[TB] FAIL mul_timing: latency=%0d in_ready_low=%0d, required 10 and 8", cycles, low);
      end
      applyOp(8'hFF, 8'hFF, 4'd12, 8'h01, 1'b1, 1'b0, 1'b0);
      applyOp(8'h03, 8'h04, 4'd0, 8'h07, 1'b0, 1'b0, 1'b0);
`else
      if (cycles != 2 || low != 0) begin
         failures++;
         $display("[TB] FAIL mul_timing: latency=%0d in_ready_low=%0d, required 2 and 0", cycles, low);
      end
`endif
      drain();
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_arith();
      test_logic();
      test_backpressure();
      test_acc();
      test_shift_illegal();
      test_mul();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
